// File: rtl/trap_ctrl_pkg.sv
// Shared XLEN, stall causes, trap FSM states and trap cause codes for the trap sequencer.
// Stands in for the ceres_param additions used by trap_ctrl.
package trap_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        NO_STALL,
        IMISS_STALL,
        DMISS_STALL,
        ALU_STALL,
        FENCEI_STALL,
        LSU_STALL
    } stall_e;

    typedef enum logic [1:0] {
        IDLE,
        TAKE,
        REDIR,
        MRET_R
    } trap_state_e;

    localparam logic [XLEN-1:0] EXC_BREAKPOINT = 32'h0000_0003;
    localparam logic [XLEN-1:0] IRQ_MSI        = 32'h8000_0003;
    localparam logic [XLEN-1:0] IRQ_MTI        = 32'h8000_0007;
    localparam logic [XLEN-1:0] IRQ_MEI        = 32'h8000_000B;

    localparam int MIP_MSIP = 3;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;

    // LSU_STALL deliberately does not hold the trap sequencer.
    function automatic logic isHeld(input stall_e stall);
        return stall inside {IMISS_STALL, DMISS_STALL, ALU_STALL, FENCEI_STALL};
    endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Multi-flop synchronizer for one asynchronous level interrupt line; clears to 0 on reset.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates breakpoints, sync exceptions and M-mode interrupts, sequences MRET.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets when mtvec_i[1:0]==1.
import trap_ctrl_pkg::*;

module trap_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  stall_e          stall_i,
    input  logic            instr_valid_i,
    input  logic [XLEN-1:0] instr_pc_i,
    input  logic            exc_valid_i,
    input  logic [XLEN-1:0] exc_cause_i,
    input  logic [XLEN-1:0] exc_tval_i,
    input  logic            mret_i,
    input  logic            sw_irq_i,
    input  logic            timer_irq_i,
    input  logic            ext_irq_i,
    input  logic            mstatus_mie_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [XLEN-1:0] tdata1_i,
    input  logic [XLEN-1:0] tdata2_i,
    output logic            trap_active_o,
    output logic [XLEN-1:0] trap_cause_o,
    output logic [XLEN-1:0] trap_mepc_o,
    output logic [XLEN-1:0] trap_tval_o,
    output logic [XLEN-1:0] mip_o,
    output logic            flush_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    trap_state_e     state_q, state_d;
    logic            pulseDone_q, pulseDone_d;
    logic [XLEN-1:0] trapCause_q, trapMepc_q, trapTval_q;
    logic            msiSync, mtiSync, meiSync;
    logic            held, bpHit, excHit, irqOk, msiHit, mtiHit, meiHit, trapHit, mretHit;
    logic            loadTrap;
    logic [XLEN-1:0] nextCause, nextTval, trapTarget;
    logic            unusedBits;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) uSyncMsi (
        .clk_i(clk_i), .rst_ni(rst_ni), .async_i(sw_irq_i),    .sync_o(msiSync));
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) uSyncMti (
        .clk_i(clk_i), .rst_ni(rst_ni), .async_i(timer_irq_i), .sync_o(mtiSync));
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) uSyncMei (
        .clk_i(clk_i), .rst_ni(rst_ni), .async_i(ext_irq_i),   .sync_o(meiSync));

    always_comb begin
        mip_o           = '0;
        mip_o[MIP_MSIP] = msiSync;
        mip_o[MIP_MTIP] = mtiSync;
        mip_o[MIP_MEIP] = meiSync;
    end

    // An MRET in execute suppresses interrupts; they are re-evaluated once MIE is restored.
    always_comb begin
        held    = isHeld(stall_i);
        bpHit   = instr_valid_i && (tdata1_i[31:28] == 4'd2) && tdata1_i[6] && tdata1_i[2]
                  && (tdata2_i != '0) && (instr_pc_i == tdata2_i);
        excHit  = instr_valid_i && exc_valid_i;
        irqOk   = instr_valid_i && mstatus_mie_i && !mret_i;
        meiHit  = irqOk && mie_i[MIP_MEIP] && mip_o[MIP_MEIP];
        msiHit  = irqOk && mie_i[MIP_MSIP] && mip_o[MIP_MSIP];
        mtiHit  = irqOk && mie_i[MIP_MTIP] && mip_o[MIP_MTIP];
        trapHit = bpHit || excHit || meiHit || msiHit || mtiHit;
        mretHit = instr_valid_i && mret_i;

        nextCause = IRQ_MTI;
        nextTval  = '0;
        if (bpHit) begin
            nextCause = EXC_BREAKPOINT;
            nextTval  = instr_pc_i;
        end else if (excHit) begin
            nextCause = exc_cause_i;
            nextTval  = exc_tval_i;
        end else if (meiHit) begin
            nextCause = IRQ_MEI;
        end else if (msiHit) begin
            nextCause = IRQ_MSI;
        end
    end

    always_comb begin
        trapTarget = {mtvec_i[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if ((mtvec_i[1:0] == 2'b01) && trapCause_q[XLEN-1]) begin
            trapTarget = {mtvec_i[XLEN-1:2], 2'b00}
                       + {{(XLEN-7){1'b0}}, trapCause_q[4:0], 2'b00};
        end
`endif
    end

    // Strobes fire on the first cycle of a state only; pulseDone_q marks a held repeat.
    always_comb begin
        state_d          = state_q;
        loadTrap         = 1'b0;
        trap_active_o    = 1'b0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        unique case (state_q)
            IDLE: begin
                if (!held) begin
                    if (trapHit) begin
                        state_d  = TAKE;
                        loadTrap = 1'b1;
                    end else if (mretHit) begin
                        state_d = MRET_R;
                    end
                end
            end
            TAKE: begin
                trap_active_o = !pulseDone_q;
                flush_o       = 1'b1;
                if (!held) state_d = REDIR;
            end
            REDIR: begin
                redirect_valid_o = !pulseDone_q;
                flush_o          = 1'b1;
                redirect_pc_o    = trapTarget;
                if (!held) state_d = IDLE;
            end
            MRET_R: begin
                redirect_valid_o = !pulseDone_q;
                flush_o          = 1'b1;
                redirect_pc_o    = mepc_i;
                if (!held) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        pulseDone_d = (state_q != IDLE) && (state_d == state_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            pulseDone_q <= 1'b0;
            trapCause_q <= '0;
            trapMepc_q  <= '0;
            trapTval_q  <= '0;
        end else begin
            state_q     <= state_d;
            pulseDone_q <= pulseDone_d;
            if (loadTrap) begin
                trapCause_q <= nextCause;
                trapMepc_q  <= instr_pc_i;
                trapTval_q  <= nextTval;
            end
        end
    end

    assign trap_cause_o = trapCause_q;
    assign trap_mepc_o  = trapMepc_q;
    assign trap_tval_o  = trapTval_q;

    assign unusedBits = ^{mie_i, tdata1_i, mtvec_i[1:0]};

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized instructions
// checked against a transaction-level model of the trap priority and redirect rules.
import trap_ctrl_pkg::*;

module tb_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    stall_e      stall_i;
    logic        instr_valid_i;
    logic [31:0] instr_pc_i;
    logic        exc_valid_i;
    logic [31:0] exc_cause_i;
    logic [31:0] exc_tval_i;
    logic        mret_i;
    logic        sw_irq_i, timer_irq_i, ext_irq_i;
    logic        mstatus_mie_i;
    logic [31:0] mie_i, mtvec_i, mepc_i, tdata1_i, tdata2_i;
    logic        trap_active_o;
    logic [31:0] trap_cause_o, trap_mepc_o, trap_tval_o, mip_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;
        logic [31:0] cause;
        logic [31:0] mepc;
        logic [31:0] tval;
        logic [31:0] target;
    } expect_t;

    typedef struct {
        logic [31:0] cause;
        logic [31:0] tval;
    } cand_t;

    localparam int K_NONE = 0;
    localparam int K_TRAP = 1;
    localparam int K_MRET = 2;

    trap_ctrl #(.SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i),
        .instr_valid_i(instr_valid_i), .instr_pc_i(instr_pc_i),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_tval_i(exc_tval_i),
        .mret_i(mret_i), .sw_irq_i(sw_irq_i), .timer_irq_i(timer_irq_i), .ext_irq_i(ext_irq_i),
        .mstatus_mie_i(mstatus_mie_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .tdata1_i(tdata1_i), .tdata2_i(tdata2_i),
        .trap_active_o(trap_active_o), .trap_cause_o(trap_cause_o),
        .trap_mepc_o(trap_mepc_o), .trap_tval_o(trap_tval_o), .mip_o(mip_o),
        .flush_o(flush_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clearInstr();
        instr_valid_i = 1'b0;
        exc_valid_i   = 1'b0;
        mret_i        = 1'b0;
        stall_i       = NO_STALL;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic exc, input logic [31:0] cause,
                                 input logic [31:0] tval, input logic mret);
        instr_valid_i = 1'b1;
        instr_pc_i    = pc;
        exc_valid_i   = exc;
        exc_cause_i   = cause;
        exc_tval_i    = tval;
        mret_i        = mret;
    endtask

    // Pending levels as the bench believes them; callers wait >= 3 cycles after changing lines.
    function automatic logic [31:0] pendingBits();
        logic [31:0] p = '0;
        p[3]  = sw_irq_i;
        p[7]  = timer_irq_i;
        p[11] = ext_irq_i;
        return p;
    endfunction

    function automatic expect_t modelStep();
        expect_t     e;
        cand_t       q[$];
        logic [31:0] pend;
        int          irqOrder[3];
        irqOrder = '{11, 3, 7};
        pend     = pendingBits();
        e.kind   = K_NONE;
        e.cause  = '0;
        e.mepc   = '0;
        e.tval   = '0;
        e.target = '0;
        if (!instr_valid_i || (stall_i inside {IMISS_STALL, DMISS_STALL, ALU_STALL, FENCEI_STALL}))
            return e;
        if (tdata1_i[31:28] == 4'd2 && tdata1_i[6] && tdata1_i[2] && tdata2_i != 0
            && tdata2_i == instr_pc_i)
            q.push_back('{32'd3, instr_pc_i});
        if (exc_valid_i)
            q.push_back('{exc_cause_i, exc_tval_i});
        if (!mret_i && mstatus_mie_i)
            foreach (irqOrder[i])
                if (mie_i[irqOrder[i]] && pend[irqOrder[i]])
                    q.push_back('{32'h8000_0000 + 32'(irqOrder[i]), 32'd0});
        if (q.size() > 0) begin
            e.kind   = K_TRAP;
            e.cause  = q[0].cause;
            e.tval   = q[0].tval;
            e.mepc   = instr_pc_i;
            e.target = mtvec_i & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
            if (mtvec_i[1:0] == 2'b01 && e.cause[31])
                e.target = e.target + 4 * (e.cause & 32'd31);
`endif
        end else if (mret_i) begin
            e.kind   = K_MRET;
            e.target = mepc_i;
        end
        return e;
    endfunction

    // Clocks the presented instruction in and follows the expected response back to idle.
    task automatic runTransaction(input expect_t e, input string tag);
        tick();
        clearInstr();
        if (e.kind == K_TRAP) begin
            checkOutput({tag, ".trapActive"}, 32'(trap_active_o), 32'd1);
            checkOutput({tag, ".flushTake"},  32'(flush_o), 32'd1);
            checkOutput({tag, ".noRedirTake"}, 32'(redirect_valid_o), 32'd0);
            checkOutput({tag, ".cause"}, trap_cause_o, e.cause);
            checkOutput({tag, ".mepc"},  trap_mepc_o, e.mepc);
            checkOutput({tag, ".tval"},  trap_tval_o, e.tval);
            tick();
            checkOutput({tag, ".redirValid"}, 32'(redirect_valid_o), 32'd1);
            checkOutput({tag, ".redirPc"}, redirect_pc_o, e.target);
            checkOutput({tag, ".noRepeatStrobe"}, 32'(trap_active_o), 32'd0);
            checkOutput({tag, ".flushRedir"}, 32'(flush_o), 32'd1);
        end else if (e.kind == K_MRET) begin
            checkOutput({tag, ".mretRedir"}, 32'(redirect_valid_o), 32'd1);
            checkOutput({tag, ".mretPc"}, redirect_pc_o, e.target);
            checkOutput({tag, ".mretNoTrap"}, 32'(trap_active_o), 32'd0);
            checkOutput({tag, ".mretFlush"}, 32'(flush_o), 32'd1);
        end else begin
            checkOutput({tag, ".noTrap"}, 32'(trap_active_o), 32'd0);
            checkOutput({tag, ".noRedir"}, 32'(redirect_valid_o), 32'd0);
            checkOutput({tag, ".noFlush"}, 32'(flush_o), 32'd0);
        end
        if (e.kind != K_NONE) begin
            tick();
            checkOutput({tag, ".idleRedir"}, 32'(redirect_valid_o), 32'd0);
            checkOutput({tag, ".idleFlush"}, 32'(flush_o), 32'd0);
        end
    endtask

    function automatic expect_t mkTrap(input logic [31:0] cause, input logic [31:0] mepc,
                                       input logic [31:0] tval, input logic [31:0] target);
        expect_t e;
        e.kind = K_TRAP; e.cause = cause; e.mepc = mepc; e.tval = tval; e.target = target;
        return e;
    endfunction

    initial begin
        expect_t     e;
        expect_t     none;
        logic [31:0] t1Opts[4];
        stall_e      stallOpts[3];
        t1Opts    = '{32'h2000_0044, 32'h2000_0040, 32'h1000_0044, 32'h0};
        stallOpts = '{NO_STALL, LSU_STALL, DMISS_STALL};
        none.kind = K_NONE; none.cause = 0; none.mepc = 0; none.tval = 0; none.target = 0;

        rst_ni = 1'b0;
        clearInstr();
        instr_pc_i = '0; exc_cause_i = '0; exc_tval_i = '0;
        sw_irq_i = 1'b0; timer_irq_i = 1'b0; ext_irq_i = 1'b0;
        mstatus_mie_i = 1'b0; mie_i = '0; mtvec_i = 32'h200; mepc_i = '0;
        tdata1_i = '0; tdata2_i = '0;
        tick(); tick();
        checkOutput("reset.trapActive", 32'(trap_active_o), 32'd0);
        checkOutput("reset.cause", trap_cause_o, 32'd0);
        checkOutput("reset.mip", mip_o, 32'd0);
        checkOutput("reset.flush", 32'(flush_o), 32'd0);
        checkOutput("reset.redirect", 32'(redirect_valid_o), 32'd0);
        checkOutput("reset.redirPc", redirect_pc_o, 32'd0);
        rst_ni = 1'b1;
        tick();

        $display("[TB] sync exception");
        applyStimulus(32'h100, 1'b1, 32'd2, 32'hDEAD, 1'b0);
        runTransaction(mkTrap(32'd2, 32'h100, 32'hDEAD, 32'h200), "exc");

        $display("[TB] timer interrupt");
        timer_irq_i = 1'b1; mie_i = 32'h80; mstatus_mie_i = 1'b1;
        tick();
        checkOutput("mipSync1", 32'(mip_o[7]), 32'd0);
        tick();
        checkOutput("mipSync2", 32'(mip_o[7]), 32'd1);
        applyStimulus(32'h300, 1'b0, 32'd0, 32'd0, 1'b0);
        runTransaction(mkTrap(32'h8000_0007, 32'h300, 32'd0, 32'h200), "mti");
        timer_irq_i = 1'b0;
        tick(); tick(); tick();

        $display("[TB] mtvec mode bits");
        mtvec_i = 32'h201; ext_irq_i = 1'b1; mie_i = 32'h800;
        tick(); tick(); tick();
        applyStimulus(32'h500, 1'b0, 32'd0, 32'd0, 1'b0);
`ifdef TRAP_VECTORED_EN
        runTransaction(mkTrap(32'h8000_000B, 32'h500, 32'd0, 32'h22C), "vecMei");
`else
        runTransaction(mkTrap(32'h8000_000B, 32'h500, 32'd0, 32'h200), "directMei");
`endif
        ext_irq_i = 1'b0; mie_i = '0;
        tick(); tick(); tick();
        applyStimulus(32'h504, 1'b1, 32'd2, 32'd0, 1'b0);
        runTransaction(mkTrap(32'd2, 32'h504, 32'd0, 32'h200), "vecExc");
        mtvec_i = 32'h200;

        $display("[TB] breakpoint");
        tdata1_i = 32'h2000_0044; tdata2_i = 32'h80;
        applyStimulus(32'h80, 1'b1, 32'd2, 32'hBEEF, 1'b0);
        runTransaction(mkTrap(32'd3, 32'h80, 32'h80, 32'h200), "bp");
        tdata2_i = 32'h0;
        applyStimulus(32'h0, 1'b0, 32'd0, 32'd0, 1'b0);
        runTransaction(none, "bpDisarmed");
        tdata1_i = '0;

        $display("[TB] mret versus pending timer");
        timer_irq_i = 1'b1; mie_i = 32'h80; mstatus_mie_i = 1'b1; mepc_i = 32'h340;
        tick(); tick(); tick();
        applyStimulus(32'h600, 1'b0, 32'd0, 32'd0, 1'b1);
        e.kind = K_MRET; e.cause = 0; e.mepc = 0; e.tval = 0; e.target = 32'h340;
        runTransaction(e, "mret");
        applyStimulus(32'h340, 1'b0, 32'd0, 32'd0, 1'b0);
        runTransaction(mkTrap(32'h8000_0007, 32'h340, 32'd0, 32'h200), "postMret");
        timer_irq_i = 1'b0; mie_i = '0;

        $display("[TB] stall in TAKE and reset in REDIR");
        ext_irq_i = 1'b1;
        tick(); tick(); tick();
        applyStimulus(32'h400, 1'b1, 32'd5, 32'h44, 1'b0);
        tick();
        clearInstr();
        stall_i = DMISS_STALL;
        checkOutput("held.firstStrobe", 32'(trap_active_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("held.noRepeat", 32'(trap_active_o), 32'd0);
            checkOutput("held.flush", 32'(flush_o), 32'd1);
            checkOutput("held.noRedir", 32'(redirect_valid_o), 32'd0);
        end
        stall_i = NO_STALL;
        tick();
        checkOutput("held.redir", 32'(redirect_valid_o), 32'd1);
        checkOutput("held.redirPc", redirect_pc_o, 32'h200);
        rst_ni = 1'b0;
        tick();
        checkOutput("rstRedir.trapActive", 32'(trap_active_o), 32'd0);
        checkOutput("rstRedir.redirect", 32'(redirect_valid_o), 32'd0);
        checkOutput("rstRedir.flush", 32'(flush_o), 32'd0);
        checkOutput("rstRedir.cause", trap_cause_o, 32'd0);
        checkOutput("rstRedir.mepc", trap_mepc_o, 32'd0);
        checkOutput("rstRedir.tval", trap_tval_o, 32'd0);
        checkOutput("rstRedir.mip", mip_o, 32'd0);
        rst_ni = 1'b1;
        ext_irq_i = 1'b0;
        tick();
        checkOutput("rstRedir.noLateRedir", 32'(redirect_valid_o), 32'd0);
        tick(); tick();

        $display("[TB] randomized instructions");
        for (int it = 0; it < 60; it++) begin
            sw_irq_i      = 1'($urandom_range(0, 1));
            timer_irq_i   = 1'($urandom_range(0, 1));
            ext_irq_i     = 1'($urandom_range(0, 1));
            mstatus_mie_i = 1'($urandom_range(0, 1));
            mie_i         = $urandom & 32'h0000_0888;
            mtvec_i       = ($urandom & 32'h0000_FFF0) | 32'($urandom_range(0, 3));
            mepc_i        = $urandom & 32'hFFFF_FFFC;
            tick(); tick(); tick();
            checkOutput("rand.mip", mip_o, pendingBits());
            applyStimulus($urandom & 32'h0000_0FFC, 1'($urandom_range(0, 1)),
                          32'($urandom_range(0, 15)), $urandom,
                          ($urandom_range(0, 3) == 0));
            tdata1_i = t1Opts[$urandom_range(0, 3)];
            case ($urandom_range(0, 2))
                0:       tdata2_i = instr_pc_i;
                1:       tdata2_i = 32'h0;
                default: tdata2_i = $urandom & 32'h0000_0FFC;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                instr_pc_i = 32'h0;
                tdata2_i   = 32'h0;
            end
            instr_valid_i = ($urandom_range(0, 7) != 0);
            stall_i       = stallOpts[$urandom_range(0, 2)];
            e = modelStep();
            runTransaction(e, $sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
